// File: rtl/vga_frame_tx.sv
// vga_frame_tx: display-side frame-buffer reader. Generates VGA raster timing
// (640x480@60 by default), reads an 8-bit grey SRC_W x SRC_H window from the
// BRAM read port and drives sync/DE/pixel pins with a fixed 2-clock latency.
// Build option: define VGA_FRAME_TX_BORDER_EN to paint the 1-pixel ring just
// outside the window white (8'hFF). Without it the ring is black like the rest.
module vga_frame_tx #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int SRC_W  = 128,
  parameter int SRC_H  = 128,
  parameter int WIN_X  = 256,
  parameter int WIN_Y  = 176
) (
  input  logic        V_CLK,
  input  logic        RESET_N,
  input  logic        ENABLE,
  output logic [13:0] BRAM_ADDR,
  input  logic [7:0]  BRAM_DOUT,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic [7:0]  VGA_PIXEL,
  output logic        VGA_DE,
  output logic        FRAME_START
);

  localparam logic [9:0] H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS_C = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C = 10'(V_VIS);
  localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [9:0] WX_BEG  = 10'(WIN_X);
  localparam logic [9:0] WX_END  = 10'(WIN_X + SRC_W - 1);
  localparam logic [9:0] WY_BEG  = 10'(WIN_Y);
  localparam logic [9:0] WY_END  = 10'(WIN_Y + SRC_H - 1);

  // Per-pixel control bundle carried down the pipeline next to the BRAM read.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic win;
    logic first;
    logic brd;
  } pix_ctl_t;

  // Idle pins: syncs deasserted (high), everything else low.
  localparam pix_ctl_t CTL_IDLE = pix_ctl_t'(6'b110000);

  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [13:0] addr_q, addr_d;
  logic        border_p0;
  pix_ctl_t    ctl_p0;
  pix_ctl_t    ctl_p1_q, ctl_p1_d;
  pix_ctl_t    ctl_p2_q, ctl_p2_d;

  // ---- Stage 0: raster counters ----
  // Advance H/V; line and frame wrap land on the same clock; disable parks at 0,0.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!ENABLE) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
    end else begin
      h_cnt_d = h_cnt_q + 10'd1;
    end
  end

`ifdef VGA_FRAME_TX_BORDER_EN
  localparam logic [9:0] BX_L = 10'(WIN_X - 1);
  localparam logic [9:0] BX_R = 10'(WIN_X + SRC_W);
  localparam logic [9:0] BY_T = 10'(WIN_Y - 1);
  localparam logic [9:0] BY_B = 10'(WIN_Y + SRC_H);

  // Flag the one-pixel ring hugging the window: side columns plus top/bottom rows.
  always_comb begin
    border_p0 = (((h_cnt_q == BX_L) || (h_cnt_q == BX_R)) &&
                 (v_cnt_q >= BY_T) && (v_cnt_q <= BY_B)) ||
                (((v_cnt_q == BY_T) || (v_cnt_q == BY_B)) &&
                 (h_cnt_q >= BX_L) && (h_cnt_q <= BX_R));
  end
`else
  assign border_p0 = 1'b0;
`endif

  // Decode sync, visible area, window and frame-start flags for the current position.
  always_comb begin
    ctl_p0       = CTL_IDLE;
    ctl_p0.de    = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
    ctl_p0.hs    = !((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END));
    ctl_p0.vs    = !((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END));
    ctl_p0.win   = (h_cnt_q >= WX_BEG) && (h_cnt_q <= WX_END) &&
                   (v_cnt_q >= WY_BEG) && (v_cnt_q <= WY_END);
    ctl_p0.first = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    ctl_p0.brd   = border_p0;
  end

  // ---- Stage 1: BRAM address ----
  // The register presents the address of the pixel decoded one clock earlier, so the
  // increment is keyed on that pixel's window flag now sitting in stage 1.
  always_comb begin
    addr_d = addr_q;
    if (!ENABLE || ctl_p0.first) begin
      addr_d = '0;
    end else if (ctl_p1_q.win) begin
      addr_d = addr_q + 14'd1;
    end
  end

  // ---- Stage 1 / Stage 2: control delay line ----
  // Disable flushes both stages so the pins go idle on the next clock.
  always_comb begin
    ctl_p1_d = ENABLE ? ctl_p0   : CTL_IDLE;
    ctl_p2_d = ENABLE ? ctl_p1_q : CTL_IDLE;
  end

  // State registers: counters, read address and the two pipeline stages.
  always_ff @(posedge V_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      addr_q   <= '0;
      ctl_p1_q <= CTL_IDLE;
      ctl_p2_q <= CTL_IDLE;
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      addr_q   <= addr_d;
      ctl_p1_q <= ctl_p1_d;
      ctl_p2_q <= ctl_p2_d;
    end
  end

  // ---- Stage 2: pins ----
  // BRAM_DOUT already arrives as a registered value aligned with stage 2, so the pixel
  // mux sits directly on it to keep every pin at the same 2-clock latency.
  assign BRAM_ADDR   = addr_q;
  assign VGA_HS      = ctl_p2_q.hs;
  assign VGA_VS      = ctl_p2_q.vs;
  assign VGA_DE      = ctl_p2_q.de;
  assign FRAME_START = ctl_p2_q.first;
  assign VGA_PIXEL   = ctl_p2_q.win ? BRAM_DOUT : (ctl_p2_q.brd ? 8'hFF : 8'h00);

endmodule

// File: tb/tb_vga_frame_tx.sv
// Bench for vga_frame_tx on a scaled-down raster (56 x 31 clocks per frame) so that
// many frames, enable drops and resets fit in a short run. A raster-position model
// predicts every pin and the BRAM address each cycle; literal timing measurements pin it.
`timescale 1ns/1ps
module tb_vga_frame_tx;

  localparam int HV  = 40, HFP = 4, HSY = 6, HBP = 6;
  localparam int VV  = 24, VFP = 2, VSY = 2, VBP = 3;
  localparam int SW  = 16, SH  = 8, WX  = 10, WY  = 5;
  localparam int HT  = HV + HFP + HSY + HBP;
  localparam int VT  = VV + VFP + VSY + VBP;
  localparam int FR  = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [13:0] bram_addr;
  logic [7:0]  bram_dout;
  logic        vga_hs, vga_vs, vga_de, frame_start;
  logic [7:0]  vga_pixel;
  logic [7:0]  mem [0:16383];

  int checks = 0;
  int failures = 0;

  int cap_tl = -1, cap_br = -1, cap_left = -1, cap_w00 = -1, cap_w35 = -1, cap_alast = -1;

  always #5 clk = ~clk;

  vga_frame_tx #(
    .H_VIS(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .SRC_W(SW), .SRC_H(SH), .WIN_X(WX), .WIN_Y(WY)
  ) dut (
    .V_CLK(clk),
    .RESET_N(rst_n),
    .ENABLE(en),
    .BRAM_ADDR(bram_addr),
    .BRAM_DOUT(bram_dout),
    .VGA_HS(vga_hs),
    .VGA_VS(vga_vs),
    .VGA_PIXEL(vga_pixel),
    .VGA_DE(vga_de),
    .FRAME_START(frame_start)
  );

  // Synchronous-read BRAM: data one clock after the address.
  always @(posedge clk) bram_dout <= mem[bram_addr];

  function automatic bit in_win(int h, int v);
    return (h >= WX) && (h < WX + SW) && (v >= WY) && (v < WY + SH);
  endfunction

`ifdef VGA_FRAME_TX_BORDER_EN
  function automatic bit on_ring(int h, int v);
    return (h >= WX - 1) && (h <= WX + SW) && (v >= WY - 1) && (v <= WY + SH) && !in_win(h, v);
  endfunction
`endif

  function automatic int clamp(int x, int lo, int hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

  // Number of window pixels lying before raster position q in the frame (mod 2^14).
  function automatic int addr_at(int q);
    int qv, qh, n;
    qv = q / HT;
    qh = q % HT;
    n  = SW * clamp(qv - WY, 0, SH);
    if (qv >= WY && qv < WY + SH) n += clamp(qh - WX, 0, SW);
    return n % 16384;
  endfunction

  // Model: raster position of the pixel being decoded, and what sits 1 and 2 clocks behind it.
  int pos, p1_pos, p2_pos;
  bit p1_v, p2_v;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos  <= 0;
      p1_v <= 1'b0;
      p2_v <= 1'b0;
    end else begin
      p2_v   <= en && p1_v;
      p2_pos <= p1_pos;
      p1_v   <= en;
      p1_pos <= pos;
      pos    <= en ? (pos + 1) % FR : 0;
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    int h, v, e_pix, e_addr;
    bit e_hs, e_vs, e_de, e_fs;
    e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_fs = 1'b0; e_pix = 0; e_addr = 0;
    if (p2_v) begin
      h    = p2_pos % HT;
      v    = p2_pos / HT;
      e_hs = !(h >= HV + HFP && h < HV + HFP + HSY);
      e_vs = !(v >= VV + VFP && v < VV + VFP + VSY);
      e_de = (h < HV) && (v < VV);
      e_fs = (p2_pos == 0);
      if (in_win(h, v)) e_pix = int'(mem[(v - WY) * SW + (h - WX)]);
`ifdef VGA_FRAME_TX_BORDER_EN
      else if (on_ring(h, v)) e_pix = 255;
`endif
      if (p2_pos == (WY - 1) * HT + WX - 1) cap_tl   = int'(vga_pixel);
      if (p2_pos == (WY + SH) * HT + WX + SW) cap_br  = int'(vga_pixel);
      if (p2_pos == WY * HT + WX - 1)       cap_left = int'(vga_pixel);
      if (p2_pos == WY * HT + WX)           cap_w00  = int'(vga_pixel);
      if (p2_pos == (WY + 2) * HT + WX + 3) cap_w35  = int'(vga_pixel);
    end
    if (p1_v) begin
      e_addr = addr_at(p1_pos);
      if (p1_pos == (WY + SH - 1) * HT + WX + SW - 1) cap_alast = int'(bram_addr);
    end
    checks++;
    if ({vga_hs, vga_vs, vga_de, frame_start} !== {e_hs, e_vs, e_de, e_fs} ||
        int'(vga_pixel) != e_pix || int'(bram_addr) != e_addr) begin
      failures++;
      $display("FAIL pins t=%0t got hs=%b vs=%b de=%b fs=%b pix=%0d addr=%0d required hs=%b vs=%b de=%b fs=%b pix=%0d addr=%0d",
               $time, vga_hs, vga_vs, vga_de, frame_start, vga_pixel, bram_addr,
               e_hs, e_vs, e_de, e_fs, e_pix, e_addr);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic bit sig(int sel);
    case (sel)
      0:       return vga_hs;
      1:       return vga_vs;
      2:       return vga_de;
      default: return frame_start;
    endcase
  endfunction

  // Count rising clock edges until the selected pin shows lvl (sampled 1 ns after the edge).
  task automatic wait_level(input int sel, input bit lvl, input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (sig(sel) != lvl && n < limit);
  endtask

  initial begin
    int n, t, r;
    rst_n = 1'b0;
    en    = 1'b1;
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);

    // Reset state, then release and measure raster timing on the pins.
    repeat (3) @(posedge clk);
    #2;
    check("reset_ctl", int'({vga_hs, vga_vs, vga_de, frame_start}), 12);
    check("reset_pix_addr", int'(vga_pixel) + int'(bram_addr), 0);
    rst_n = 1'b1;

    wait_level(0, 1'b0, 200, n);   check("hs_first_fall", n, HV + HFP + 2);
    t = n;
    wait_level(0, 1'b1, 200, n);   check("hs_low", n, 6);
    t += n;
    wait_level(0, 1'b0, 200, n);   check("hs_period", n + 6, 56);
    t += n;
    wait_level(1, 1'b0, 4000, n);  check("vs_first_fall", t + n, 26 * 56 + 2);
    wait_level(1, 1'b1, 4000, n);  check("vs_low", n, 112);
    wait_level(1, 1'b0, 4000, n);  check("vs_period", n + 112, 1736);
    wait_level(3, 1'b1, 4000, n);
    wait_level(3, 1'b0, 10, n);    check("fs_width", n, 1);
    wait_level(3, 1'b1, 4000, n);  check("fs_period", n + 1, 1736);
    wait_level(2, 1'b0, 200, n);
    wait_level(2, 1'b1, 200, n);   check("de_low", n, 16);
    wait_level(2, 1'b0, 200, n);   check("de_high", n, 40);

    // Drop ENABLE mid-frame, then re-raise it.
    t = 0;
    do begin @(posedge clk); #2; t++; end while (pos != 20 * HT + 7 && t < 4 * FR);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("dis_ctl", int'({vga_hs, vga_vs, vga_de, frame_start}), 12);
    check("dis_pix_addr", int'(vga_pixel) + int'(bram_addr), 0);
    repeat (8) @(posedge clk);
    #2;
    en = 1'b1;
    wait_level(3, 1'b1, 20, n);    check("reenable_fs", n, 2);

    // Asynchronous reset pulse mid-line.
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_ctl", int'({vga_hs, vga_vs, vga_de, frame_start}), 12);
    check("midreset_pix_addr", int'(vga_pixel) + int'(bram_addr), 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    wait_level(0, 1'b0, 200, n);   check("midreset_hs_fall", n, HV + HFP + 2);

    // Random ENABLE drops and reset pulses.
    for (int c = 0; c < 24000; c++) begin
      @(posedge clk);
      #2;
      r = int'($urandom_range(0, 1999));
      if (!rst_n) rst_n = (r < 1000);
      else if (r == 0) rst_n = 1'b0;
      if (en) en = (r != 1);
      else en = (r < 600);
    end

    // Clean full frame before the final spot checks.
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (2 * FR) @(posedge clk);
    #1;

`ifdef VGA_FRAME_TX_BORDER_EN
    check("ring_top_left", cap_tl, 255);
    check("ring_bottom_right", cap_br, 255);
    check("left_of_window", cap_left, 255);
`else
    check("ring_top_left", cap_tl, 0);
    check("ring_bottom_right", cap_br, 0);
    check("left_of_window", cap_left, 0);
`endif
    check("window_0_0", cap_w00, int'(mem[0]));
    check("window_3_2", cap_w35, int'(mem[35]));
    check("addr_last_window", cap_alast, 127);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
